// File: rtl/marsohod2_wb_gpio.sv
// -----------------------------------------------------------------------------
// marsohod2_wb_gpio
// Wishbone B3 classic slave driving the marsohod2 LEDs and the IO[7:0] header,
// sampling IO inputs and the KEY1 button (synchronised, debounced), latching
// sticky edge events and raising a level interrupt.
//
// Ports
//   wb_clk_i, wb_rst_n_i        bus clock, asynchronous active-low reset
//   wb_adr_i/dat_i/sel_i/we_i   Wishbone request (only adr[4:2] decoded)
//   wb_cyc_i, wb_stb_i          Wishbone cycle / strobe
//   wb_dat_o, wb_ack_o          registered read data and acknowledge
//   led_o                       LED drive, active high
//   io_o, io_oe_o               IO output data and per-bit output enable
//   io_i                        IO pad input (asynchronous)
//   key_n_i                     KEY1 pad, low = pressed (asynchronous)
//   irq_o                       level interrupt, active high
//
// Register map (adr[4:2]):
//   0 LED_OUT[3:0] rw   1 IO_OUT[7:0] rw   2 IO_OE[7:0] rw   3 IO_IN[7:0] ro
//   4 KEY[0] ro         5 EDGE rw1c ([0] key press, [15:8] IO rising edges)
//   6 IRQ_EN rw (EDGE layout)               7 reads 0, writes ignored
// -----------------------------------------------------------------------------
module marsohod2_wb_gpio #(
  parameter int unsigned DEBOUNCE_CYCLES = 240000,
  parameter logic [3:0]  LED_RESET       = 4'h0
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic [3:0]  led_o,
  output logic [7:0]  io_o,
  output logic [7:0]  io_oe_o,
  input  logic [7:0]  io_i,
  input  logic        key_n_i,
  output logic        irq_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    REG_LED    = 3'd0,
    REG_IO_OUT = 3'd1,
    REG_IO_OE  = 3'd2,
    REG_IO_IN  = 3'd3,
    REG_KEY    = 3'd4,
    REG_EDGE   = 3'd5,
    REG_IRQ_EN = 3'd6,
    REG_NONE   = 3'd7
  } reg_e;

  // Bus side state
  logic        ack_q;
  logic [31:0] dat_q;
  logic [3:0]  led_q,   led_d;
  logic [7:0]  io_out_q, io_out_d;
  logic [7:0]  io_oe_q,  io_oe_d;
  logic        irq_en_key_q, irq_en_key_d;
  logic [7:0]  irq_en_io_q,  irq_en_io_d;
  logic        key_edge_q,   key_edge_d;
  logic [7:0]  io_edge_q,    io_edge_d;
  logic        irq_q;

  // Input side state
  logic [7:0]  io_s1_q, io_s2_q, io_prev_q;
  logic        key_s1_q, key_s2_q;
  logic        key_deb_q, key_deb_d;     // 1 = debounced pressed
  logic [CW-1:0] cnt_q, cnt_d;
  logic        key_press_evt;

  reg_e        reg_sel;
  logic        xfer_start;
  logic        wr;
  logic [31:0] rdata;
  logic [7:0]  io_rise;
  logic        key_clr;
  logic [7:0]  io_clr;

  assign reg_sel    = reg_e'(wb_adr_i[4:2]);
  // A new transfer is accepted on any cycle the previous one is not being acked;
  // the write commits on the same edge that raises ack.
  assign xfer_start = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr         = xfer_start & wb_we_i;

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_LED:    rdata[3:0]  = led_q;
      REG_IO_OUT: rdata[7:0]  = io_out_q;
      REG_IO_OE:  rdata[7:0]  = io_oe_q;
      REG_IO_IN:  rdata[7:0]  = io_s2_q;
      REG_KEY:    rdata[0]    = key_deb_q;
      REG_EDGE: begin
        rdata[0]    = key_edge_q;
        rdata[15:8] = io_edge_q;
      end
      REG_IRQ_EN: begin
        rdata[0]    = irq_en_key_q;
        rdata[15:8] = irq_en_io_q;
      end
      default:    rdata = '0;
    endcase
  end

  always_comb begin
    led_d        = led_q;
    io_out_d     = io_out_q;
    io_oe_d      = io_oe_q;
    irq_en_key_d = irq_en_key_q;
    irq_en_io_d  = irq_en_io_q;
    if (wr) begin
      case (reg_sel)
        REG_LED:    if (wb_sel_i[0]) led_d    = wb_dat_i[3:0];
        REG_IO_OUT: if (wb_sel_i[0]) io_out_d = wb_dat_i[7:0];
        REG_IO_OE:  if (wb_sel_i[0]) io_oe_d  = wb_dat_i[7:0];
        REG_IRQ_EN: begin
          if (wb_sel_i[0]) irq_en_key_d = wb_dat_i[0];
          if (wb_sel_i[1]) irq_en_io_d  = wb_dat_i[15:8];
        end
        default: ;
      endcase
    end
  end

  // Debounce: count consecutive cycles the synced key disagrees with the
  // debounced level; flip only after DEBOUNCE_CYCLES disagreeing cycles.
  always_comb begin
    key_deb_d     = key_deb_q;
    cnt_d         = '0;
    key_press_evt = 1'b0;
    if (~key_s2_q != key_deb_q) begin
      if (cnt_q == CNT_MAX) begin
        key_deb_d     = ~key_deb_q;
        key_press_evt = ~key_deb_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Sticky edges: a set arriving in the clearing cycle wins over the clear.
  assign io_rise = io_s2_q & ~io_prev_q;
  assign key_clr = wr & (reg_sel == REG_EDGE) & wb_sel_i[0] & wb_dat_i[0];
  assign io_clr  = {8{wr & (reg_sel == REG_EDGE) & wb_sel_i[1]}} & wb_dat_i[15:8];

  always_comb begin
    key_edge_d = (key_edge_q & ~key_clr) | key_press_evt;
    io_edge_d  = (io_edge_q & ~io_clr) | io_rise;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      ack_q        <= 1'b0;
      dat_q        <= '0;
      led_q        <= LED_RESET;
      io_out_q     <= '0;
      io_oe_q      <= '0;
      irq_en_key_q <= 1'b0;
      irq_en_io_q  <= '0;
      key_edge_q   <= 1'b0;
      io_edge_q    <= '0;
      irq_q        <= 1'b0;
      io_s1_q      <= '0;
      io_s2_q      <= '0;
      io_prev_q    <= '0;
      key_s1_q     <= 1'b1;
      key_s2_q     <= 1'b1;
      key_deb_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      ack_q        <= xfer_start;
      dat_q        <= xfer_start ? rdata : '0;
      led_q        <= led_d;
      io_out_q     <= io_out_d;
      io_oe_q      <= io_oe_d;
      irq_en_key_q <= irq_en_key_d;
      irq_en_io_q  <= irq_en_io_d;
      key_edge_q   <= key_edge_d;
      io_edge_q    <= io_edge_d;
      irq_q        <= |({io_edge_q, key_edge_q} & {irq_en_io_q, irq_en_key_q});
      io_s1_q      <= io_i;
      io_s2_q      <= io_s1_q;
      io_prev_q    <= io_s2_q;
      key_s1_q     <= key_n_i;
      key_s2_q     <= key_s1_q;
      key_deb_q    <= key_deb_d;
      cnt_q        <= cnt_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign led_o    = led_q;
  assign io_o     = io_out_q;
  assign io_oe_o  = io_oe_q;
  assign irq_o    = irq_q;

  logic unused_bits;
  assign unused_bits = ^{wb_adr_i[31:5], wb_adr_i[1:0], wb_dat_i[31:16], wb_sel_i[3:2]};

endmodule

// File: tb/tb_marsohod2_wb_gpio.sv
module tb_marsohod2_wb_gpio;

  localparam int unsigned DEB = 4;
  localparam logic [3:0]  LEDR = 4'h3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] wb_adr, wb_dat, wb_dat_o;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_cyc, wb_stb, wb_ack;
  logic [3:0]  led;
  logic [7:0]  io_o, io_oe, io_in;
  logic        key_n, irq;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [3:0]  m_led;
  logic [7:0]  m_io_out, m_oe;
  logic [15:0] m_edge, m_irqen;
  logic        m_key;

  marsohod2_wb_gpio #(.DEBOUNCE_CYCLES(DEB), .LED_RESET(LEDR)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat),
    .wb_sel_i(wb_sel), .wb_we_i(wb_we), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack), .led_o(led), .io_o(io_o),
    .io_oe_o(io_oe), .io_i(io_in), .key_n_i(key_n), .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_led = LEDR; m_io_out = '0; m_oe = '0; m_edge = '0; m_irqen = '0; m_key = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] idx);
    case (idx)
      3'd0: return {28'd0, m_led};
      3'd1: return {24'd0, m_io_out};
      3'd2: return {24'd0, m_oe};
      3'd3: return {24'd0, io_in};
      3'd4: return {31'd0, m_key};
      3'd5: return {16'd0, m_edge};
      3'd6: return {16'd0, m_irqen};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_write(input logic [2:0] idx, input logic [31:0] d, input logic [3:0] s);
    case (idx)
      3'd0: if (s[0]) m_led = d[3:0];
      3'd1: if (s[0]) m_io_out = d[7:0];
      3'd2: if (s[0]) m_oe = d[7:0];
      3'd5: begin
        if (s[0] && d[0]) m_edge[0] = 1'b0;
        if (s[1]) m_edge[15:8] = m_edge[15:8] & ~d[15:8];
      end
      3'd6: begin
        if (s[0]) m_irqen[0] = d[0];
        if (s[1]) m_irqen[15:8] = d[15:8];
      end
      default: ;
    endcase
  endtask

  function automatic logic model_irq();
    return |(m_edge & m_irqen);
  endfunction

  // One classic transfer starting 1 ns after a rising edge. ack_ok means ack was
  // low at the strobe, high exactly one edge later and low again the edge after.
  task automatic wb_xfer(input logic we, input logic [2:0] idx, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rd,
                         output logic ack_ok, output logic irq_at_ack);
    logic pre, a1;
    wb_adr = $urandom;
    wb_adr[4:2] = idx;
    wb_dat = d; wb_sel = s; wb_we = we; wb_cyc = 1'b1; wb_stb = 1'b1;
    pre = wb_ack;
    @(posedge clk); #1;
    rd = wb_dat_o; a1 = wb_ack; irq_at_ack = irq;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    @(posedge clk); #1;
    ack_ok = !pre && a1 && !wb_ack;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic ok, ia;
    rst_n = 1'b0; tick(3);
    model_reset();
    if (led !== LEDR) begin $display("FAIL reset_led got %h want %h", led, LEDR); miscompares++; end
    vectors++;
    if ({io_o, io_oe} !== 16'h0) begin $display("FAIL reset_io got %h want 0", {io_o, io_oe}); miscompares++; end
    vectors++;
    if ({wb_ack, irq, wb_dat_o} !== 34'h0) begin $display("FAIL reset_bus got %h want 0", {wb_ack, irq, wb_dat_o}); miscompares++; end
    vectors++;
    rst_n = 1'b1; tick(1);
    for (int i = 0; i < 8; i++) begin
      wb_xfer(1'b0, 3'(i), 32'h0, 4'hF, rd, ok, ia);
      if (!ok) begin $display("FAIL reset_ack[%0d] got 0 want 1", i); miscompares++; end
      vectors++;
      if (rd !== model_read(3'(i))) begin $display("FAIL reset_read[%0d] got %h want %h", i, rd, model_read(3'(i))); miscompares++; end
      vectors++;
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd, d; logic ok, ia, we; logic [2:0] idx; logic [3:0] s;
    wb_xfer(1'b1, 3'd0, 32'hFFFF_FFF5, 4'b0001, rd, ok, ia); model_write(3'd0, 32'hFFFF_FFF5, 4'b0001);
    if (led !== 4'h5) begin $display("FAIL lane_led got %h want 5", led); miscompares++; end
    vectors++;
    wb_xfer(1'b1, 3'd2, 32'hA5, 4'b0010, rd, ok, ia);
    if (io_oe !== 8'h00) begin $display("FAIL lane_oe_gated got %h want 00", io_oe); miscompares++; end
    vectors++;
    wb_xfer(1'b1, 3'd2, 32'hA5, 4'hF, rd, ok, ia); model_write(3'd2, 32'hA5, 4'hF);
    if (io_oe !== 8'hA5) begin $display("FAIL lane_oe got %h want a5", io_oe); miscompares++; end
    vectors++;
    for (int i = 0; i < 24; i++) begin
      idx = 3'($urandom_range(0, 7)); d = $urandom; s = 4'($urandom_range(0, 15)); we = 1'($urandom_range(0, 1));
      wb_xfer(we, idx, d, s, rd, ok, ia);
      if (we) model_write(idx, d, s);
      else begin
        if (rd !== model_read(idx)) begin $display("FAIL rand_read[%0d] got %h want %h", idx, rd, model_read(idx)); miscompares++; end
        vectors++;
      end
      if (!ok) begin $display("FAIL rand_ack got 0 want 1"); miscompares++; end
      vectors++;
      if ({led, io_o, io_oe, irq} !== {m_led, m_io_out, m_oe, model_irq()}) begin
        $display("FAIL rand_outputs got %h want %h", {led, io_o, io_oe, irq}, {m_led, m_io_out, m_oe, model_irq()});
        miscompares++;
      end
      vectors++;
    end
  endtask

  task automatic test_held_strobe();
    logic [3:0] pat;
    wb_adr = 32'h0; wb_we = 1'b0; wb_sel = 4'hF; wb_cyc = 1'b1; wb_stb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      pat[i] = wb_ack;
      if (wb_ack && wb_dat_o !== {28'd0, m_led}) begin $display("FAIL held_data got %h want %h", wb_dat_o, m_led); miscompares++; end
      vectors++;
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; tick(1);
    if (pat !== 4'b0101) begin $display("FAIL held_ack_pattern got %b want 0101", pat); miscompares++; end
    vectors++;
  endtask

  task automatic glitch(input int n);
    key_n = 1'b0; tick(n); key_n = 1'b1;
  endtask

  task automatic check_key_edge(input string tag);
    logic [31:0] rd; logic ok, ia;
    wb_xfer(1'b0, 3'd4, 32'h0, 4'hF, rd, ok, ia);
    if (rd !== model_read(3'd4)) begin $display("FAIL %s_key got %h want %h", tag, rd, model_read(3'd4)); miscompares++; end
    vectors++;
    wb_xfer(1'b0, 3'd5, 32'h0, 4'hF, rd, ok, ia);
    if (rd !== model_read(3'd5)) begin $display("FAIL %s_edge got %h want %h", tag, rd, model_read(3'd5)); miscompares++; end
    vectors++;
  endtask

  task automatic test_debounce();
    logic [31:0] rd; logic ok, ia; logic [3:0] seen;
    wb_xfer(1'b1, 3'd6, 32'h0, 4'hF, rd, ok, ia); model_write(3'd6, 32'h0, 4'hF);
    glitch(2); tick(8); check_key_edge("glitch2");
    glitch(DEB - 1); tick(8); check_key_edge("glitch3");
    // Held press: debounced level flips 2 sync + DEB cycles after the pin falls.
    key_n = 1'b0; tick(1);
    for (int i = 0; i < 4; i++) begin
      wb_xfer(1'b0, 3'd4, 32'h0, 4'hF, rd, ok, ia);
      seen[i] = rd[0];
    end
    if (seen !== 4'b1000) begin $display("FAIL key_latency got %b want 1000", seen); miscompares++; end
    vectors++;
    m_key = 1'b1; m_edge[0] = 1'b1;
    check_key_edge("pressed");
    key_n = 1'b1; tick(10); m_key = 1'b0;
    check_key_edge("released");
    wb_xfer(1'b1, 3'd5, 32'h1, 4'b0001, rd, ok, ia); model_write(3'd5, 32'h1, 4'b0001);
    glitch(DEB); tick(10); m_edge[0] = 1'b1;
    check_key_edge("glitch4");
  endtask

  task automatic test_irq();
    logic [31:0] rd; logic ok, ia;
    wb_xfer(1'b1, 3'd5, 32'hFFFF, 4'hF, rd, ok, ia); model_write(3'd5, 32'hFFFF, 4'hF);
    wb_xfer(1'b1, 3'd6, 32'h1, 4'hF, rd, ok, ia); model_write(3'd6, 32'h1, 4'hF);
    if (irq !== 1'b0) begin $display("FAIL irq_idle got %b want 0", irq); miscompares++; end
    vectors++;
    key_n = 1'b0; tick(10); m_key = 1'b1; m_edge[0] = 1'b1;
    if (irq !== 1'b1) begin $display("FAIL irq_press got %b want 1", irq); miscompares++; end
    vectors++;
    key_n = 1'b1; tick(10); m_key = 1'b0;
    // io_i[3] rises so that its synced edge lands on the clearing write's commit edge.
    io_in = 8'h08; tick(2);
    wb_xfer(1'b1, 3'd5, 32'hFF01, 4'b0011, rd, ok, ia);
    model_write(3'd5, 32'hFF01, 4'b0011); m_edge[11] = 1'b1;
    if (ia !== 1'b1) begin $display("FAIL irq_at_clear_ack got %b want 1", ia); miscompares++; end
    vectors++;
    if (irq !== model_irq()) begin $display("FAIL irq_after_clear got %b want %b", irq, model_irq()); miscompares++; end
    vectors++;
    check_key_edge("set_over_clear");
  endtask

  task automatic test_io_edges();
    logic [31:0] rd; logic ok, ia; logic [7:0] nv, old; logic [31:0] d;
    io_in = 8'h00; tick(4);
    wb_xfer(1'b1, 3'd5, 32'hFF01, 4'b0011, rd, ok, ia); model_write(3'd5, 32'hFF01, 4'b0011);
    io_in = 8'h81; tick(1);
    wb_xfer(1'b0, 3'd3, 32'h0, 4'hF, rd, ok, ia);
    if (rd !== 32'h00) begin $display("FAIL io_in_early got %h want 00", rd); miscompares++; end
    vectors++;
    wb_xfer(1'b0, 3'd3, 32'h0, 4'hF, rd, ok, ia);
    if (rd !== 32'h81) begin $display("FAIL io_in_sync got %h want 81", rd); miscompares++; end
    vectors++;
    m_edge[15:8] = m_edge[15:8] | 8'h81;
    check_key_edge("io81");
    wb_xfer(1'b1, 3'd5, 32'h8000, 4'b0010, rd, ok, ia); model_write(3'd5, 32'h8000, 4'b0010);
    check_key_edge("io_clr80");
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      wb_xfer(1'b1, 3'd6, d, 4'hF, rd, ok, ia); model_write(3'd6, d, 4'hF);
      old = io_in; nv = 8'($urandom); io_in = nv; tick(4);
      m_edge[15:8] = m_edge[15:8] | (nv & ~old);
      d = $urandom;
      wb_xfer(1'b1, 3'd5, d, 4'($urandom_range(0, 15)), rd, ok, ia); model_write(3'd5, d, wb_sel);
      if (irq !== model_irq()) begin $display("FAIL io_irq got %b want %b", irq, model_irq()); miscompares++; end
      vectors++;
      wb_xfer(1'b0, 3'd3, 32'h0, 4'hF, rd, ok, ia);
      if (rd !== model_read(3'd3)) begin $display("FAIL io_in_rand got %h want %h", rd, model_read(3'd3)); miscompares++; end
      vectors++;
      check_key_edge("io_rand");
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic ok, ia;
    io_in = 8'h00; tick(4);
    wb_xfer(1'b1, 3'd0, 32'h9, 4'b0001, rd, ok, ia); model_write(3'd0, 32'h9, 4'b0001);
    wb_adr = 32'h0; wb_dat = 32'h6; wb_sel = 4'hF; wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
    #3;
    if ({led, wb_ack} !== {4'h9, 1'b0}) begin $display("FAIL mid_pre got %h want 12", {led, wb_ack}); miscompares++; end
    vectors++;
    rst_n = 1'b0; #1;
    if ({led, wb_ack, io_oe} !== {LEDR, 1'b0, 8'h00}) begin
      $display("FAIL mid_reset got %h want %h", {led, wb_ack, io_oe}, {LEDR, 1'b0, 8'h00}); miscompares++;
    end
    vectors++;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    tick(2); rst_n = 1'b1; model_reset(); tick(1);
    if (led !== LEDR) begin $display("FAIL mid_after got %h want %h", led, LEDR); miscompares++; end
    vectors++;
    wb_xfer(1'b1, 3'd0, 32'hC, 4'b0001, rd, ok, ia); model_write(3'd0, 32'hC, 4'b0001);
    for (int i = 0; i < 8; i++) begin
      wb_xfer(1'b0, 3'(i), 32'h0, 4'hF, rd, ok, ia);
      if (!ok || rd !== model_read(3'(i))) begin
        $display("FAIL resume_read[%0d] got %h ack %b want %h", i, rd, ok, model_read(3'(i))); miscompares++;
      end
      vectors++;
    end
  endtask

  initial begin
    rst_n = 1'b0; wb_adr = '0; wb_dat = '0; wb_sel = '0; wb_we = 1'b0;
    wb_cyc = 1'b0; wb_stb = 1'b0; io_in = '0; key_n = 1'b1;
    model_reset();
    test_reset();
    test_byte_lanes();
    test_held_strobe();
    test_debounce();
    test_irq();
    test_io_edges();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
